// File: rtl/obj_mem_ctrl_if.sv
// Bundled request, table, memory and response signals of the object memory sequencer.
// master = the sequencer itself, slave = the requester/table/memory environment.
interface obj_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_obj;
  logic [7:0]  req_off;
  logic [15:0] req_wdata;
  logic [3:0]  ref_ptr;
  logic [7:0]  ref_off;
  logic        ref_rd;
  logic [15:0] ref_loc;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    input  req_valid, req_we, req_obj, req_off, req_wdata,
    input  ref_loc, mem_ack, mem_rdata,
    output req_ready, ref_ptr, ref_off, ref_rd,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output req_valid, req_we, req_obj, req_off, req_wdata,
    output ref_loc, mem_ack, mem_rdata,
    input  req_ready, ref_ptr, ref_off, ref_rd,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/obj_mem_ctrl.sv
// Object memory access sequencer: object/offset -> table lookup -> one memory access -> response.
// Optional address range check is enabled by defining OBJ_ADDR_CHECK_EN.
module obj_mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  obj_mem_ctrl_if.master bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] MEM     = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_r;
  logic        lookup_hold_r;
  logic        we_r;
  logic [3:0]  obj_r;
  logic [7:0]  off_r;
  logic [15:0] wdata_r;
  logic [7:0]  tmo_cnt_r;
  logic        req_ready_r;
  logic [3:0]  ref_ptr_r;
  logic [7:0]  ref_off_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [15:0] mem_addr_r;
  logic [15:0] mem_wdata_r;
  logic        rsp_valid_r;
  logic [15:0] rsp_rdata_r;
  logic        rsp_err_r;
  logic        addr_err_s;

`ifdef OBJ_ADDR_CHECK_EN
  // Objects 8..15 are unpopulated; locations outside the data window indicate wrap.
  always_comb begin
    addr_err_s = 1'b0;
    if ((obj_r >= 4'd8) || (bus.ref_loc < 16'h0100) || (bus.ref_loc > 16'h08FF)) begin
      addr_err_s = 1'b1;
    end else begin
      addr_err_s = 1'b0;
    end
  end
`else
  assign addr_err_s = 1'b0;
`endif

  // Sequencer state, request capture and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      lookup_hold_r <= 1'b0;
      we_r          <= 1'b0;
      obj_r         <= 4'd0;
      off_r         <= 8'd0;
      wdata_r       <= 16'd0;
      tmo_cnt_r     <= 8'd0;
      req_ready_r   <= 1'b1;
      ref_ptr_r     <= 4'd0;
      ref_off_r     <= 8'd0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= 16'd0;
      mem_wdata_r   <= 16'd0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 16'd0;
      rsp_err_r     <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            we_r          <= bus.req_we;
            obj_r         <= bus.req_obj;
            off_r         <= bus.req_off;
            wdata_r       <= bus.req_wdata;
            req_ready_r   <= 1'b0;
            lookup_hold_r <= 1'b0;
            state_r       <= LOOKUP;
          end
        end
        LOOKUP: begin
          // First cycle loads the table-facing registers, second lets the table sample them.
          if (!lookup_hold_r) begin
            ref_ptr_r     <= obj_r;
            ref_off_r     <= off_r;
            lookup_hold_r <= 1'b1;
          end else begin
            lookup_hold_r <= 1'b0;
            state_r       <= CAPTURE;
          end
        end
        CAPTURE: begin
          mem_addr_r <= bus.ref_loc;
          if (addr_err_s) begin
            rsp_rdata_r <= 16'd0;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= we_r;
            mem_wdata_r <= wdata_r;
            tmo_cnt_r   <= 8'd0;
            state_r     <= MEM;
          end
        end
        MEM: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (bus.mem_ack) begin
            mem_req_r   <= 1'b0;
            rsp_rdata_r <= we_r ? 16'd0 : bus.mem_rdata;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
          end else if (tmo_cnt_r == TMO_LAST) begin
            mem_req_r   <= 1'b0;
            rsp_rdata_r <= 16'd0;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        DONE: begin
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          mem_req_r   <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.ref_ptr   = ref_ptr_r;
  assign bus.ref_off   = ref_off_r;
  assign bus.ref_rd    = 1'b1;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_obj_mem_ctrl.sv
// Directed bench for obj_mem_ctrl with a registered object table model and a scripted memory.
// Cycle indices count negedges after the accept edge E (index 0 = cycle after E).
module tb_obj_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  obj_mem_ctrl_if bus();
  obj_mem_ctrl #(.TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int n_vec = 0;
  int n_err = 0;
  int ref_rd_low = 0;

  int          rise, len, rsp_at, pulses;
  logic [15:0] got_rdata, got_addr, got_wdata;
  logic        got_err, got_we, ready_after;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Table: object p (0..7) based at 0x0100*(p+1); unpopulated objects read as base 0.
  function automatic logic [15:0] tbl_base(input logic [3:0] p);
    logic [3:0] q;
    q = p + 4'd1;
    if (p < 4'd8) return {4'h0, q, 8'h00};
    else          return 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (bus.ref_rd) bus.ref_loc <= tbl_base(bus.ref_ptr) + {8'h00, bus.ref_off};
  end

  always @(negedge clk) begin
    if (bus.ref_rd !== 1'b1) ref_rd_low++;
  end

  task automatic issue_only(input logic we, input logic [3:0] obj, input logic [7:0] off,
                            input logic [15:0] wd);
    int w;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check_vec("ready_wait", 64'd0, 64'd1);
    bus.req_we    = we;
    bus.req_obj   = obj;
    bus.req_off   = off;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // ack_at = which MEM cycle (1-based) gets mem_ack; 0 = never.
  task automatic run_txn(input logic we, input logic [3:0] obj, input logic [7:0] off,
                         input logic [15:0] wd, input int ack_at, input logic [15:0] rd);
    rise = -1; len = 0; rsp_at = -1; pulses = 0;
    got_rdata = 16'd0; got_addr = 16'd0; got_wdata = 16'd0;
    got_err = 1'b0; got_we = 1'b0; ready_after = 1'b0;
    issue_only(we, obj, off, wd);
    for (int n = 0; n < 40; n++) begin
      bus.mem_ack = 1'b0;
      if (n == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
      end
      if (bus.mem_req) begin
        if (rise < 0) begin
          rise = n; got_addr = bus.mem_addr; got_we = bus.mem_we; got_wdata = bus.mem_wdata;
        end
        len++;
        if (len == ack_at) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd;
        end
      end
      if (bus.rsp_valid) begin
        pulses++;
        if (rsp_at < 0) begin
          rsp_at = n; got_rdata = bus.rsp_rdata; got_err = bus.rsp_err;
        end
      end
      if (rsp_at >= 0 && n == rsp_at + 1) begin
        ready_after = bus.req_ready;
        break;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic expect_txn(input string tag, input int e_rise, input int e_len, input int e_rsp,
                            input logic [15:0] e_rdata, input logic e_err);
    check_vec({tag, "_req_rise"}, rise, e_rise);
    check_vec({tag, "_req_len"}, len, e_len);
    check_vec({tag, "_rsp_cycle"}, rsp_at, e_rsp);
    check_vec({tag, "_rsp_rdata"}, got_rdata, e_rdata);
    check_vec({tag, "_rsp_err"}, got_err, e_err);
    check_vec({tag, "_pulses"}, pulses, 1);
    check_vec({tag, "_ready_after"}, ready_after, 1'b1);
  endtask

  int acc_at[2];
  int rsp_n[2];
  logic [15:0] rd_b[2];
  int accepts, acks, cnt;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_obj = 4'd0; bus.req_off = 8'd0;
    bus.req_wdata = 16'd0; bus.mem_ack = 1'b0; bus.mem_rdata = 16'd0;
    repeat (2) @(negedge clk);
    check_vec("rst_ctrl", {bus.req_ready, bus.ref_rd, bus.mem_req, bus.mem_we, bus.rsp_valid, bus.rsp_err}, 6'b110000);
    check_vec("rst_ref", {bus.ref_ptr, bus.ref_off}, 12'h000);
    check_vec("rst_data", {bus.mem_addr, bus.mem_wdata, bus.rsp_rdata}, 48'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 4'd2, 8'h10, 16'h0000, 1, 16'hBEEF);
    expect_txn("ld_obj2", 3, 1, 4, 16'hBEEF, 1'b0);
    check_vec("ld_obj2_addr", got_addr, 16'h0310);
    check_vec("ld_obj2_we", got_we, 1'b0);
    check_vec("ld_obj2_hold", bus.rsp_rdata, 16'hBEEF);

    run_txn(1'b1, 4'd7, 8'hFF, 16'h1234, 4, 16'h7777);
    expect_txn("st_obj7", 3, 4, 7, 16'h0000, 1'b0);
    check_vec("st_obj7_addr", got_addr, 16'h08FF);
    check_vec("st_obj7_we", got_we, 1'b1);
    check_vec("st_obj7_wdata", got_wdata, 16'h1234);

    run_txn(1'b0, 4'd1, 8'h20, 16'h0000, 0, 16'h0000);
    expect_txn("timeout", 3, 15, 18, 16'h0000, 1'b1);
    check_vec("timeout_addr", got_addr, 16'h0220);

    run_txn(1'b0, 4'd5, 8'h01, 16'h0000, 15, 16'h4321);
    expect_txn("ack_at_limit", 3, 15, 18, 16'h4321, 1'b0);
    check_vec("ack_at_limit_addr", got_addr, 16'h0601);

`ifdef OBJ_ADDR_CHECK_EN
    run_txn(1'b0, 4'd9, 8'h04, 16'h0000, 1, 16'h5A5A);
    expect_txn("obj9_chk", -1, 0, 3, 16'h0000, 1'b1);
`else
    run_txn(1'b0, 4'd9, 8'h04, 16'h0000, 1, 16'h5A5A);
    expect_txn("obj9_nochk", 3, 1, 4, 16'h5A5A, 1'b0);
    check_vec("obj9_nochk_addr", got_addr, 16'h0004);
`endif

    // Reset while the memory request is in flight.
    issue_only(1'b0, 4'd3, 8'h00, 16'h0000);
    cnt = 0;
    while (!bus.mem_req && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check_vec("abort_pre_req", bus.mem_req, 1'b1);
    rst = 1'b1;
    #1;
    check_vec("abort_ctrl", {bus.req_ready, bus.ref_rd, bus.mem_req, bus.mem_we, bus.rsp_valid, bus.rsp_err}, 6'b110000);
    check_vec("abort_data", {bus.mem_addr, bus.mem_wdata, bus.rsp_rdata, bus.ref_ptr, bus.ref_off}, 60'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid) cnt++;
      @(negedge clk);
    end
    check_vec("abort_no_rsp", cnt, 0);
    run_txn(1'b0, 4'd0, 8'h00, 16'h0000, 2, 16'hC0DE);
    expect_txn("post_abort", 3, 2, 5, 16'hC0DE, 1'b0);
    check_vec("post_abort_addr", got_addr, 16'h0100);

    // Back-to-back loads with req_valid held high.
    accepts = 0; acks = 0; cnt = 0;
    acc_at[0] = -1; acc_at[1] = -1; rsp_n[0] = -1; rsp_n[1] = -1;
    rd_b[0] = 16'd0; rd_b[1] = 16'd0;
    bus.req_we = 1'b0; bus.req_obj = 4'd4; bus.req_off = 8'h02; bus.req_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      bus.mem_ack = 1'b0;
      if (accepts == 2 && bus.req_valid) bus.req_valid = 1'b0;
      if (bus.req_ready && bus.req_valid) begin
        if (accepts < 2) acc_at[accepts] = n;
        accepts++;
      end
      if (bus.mem_req) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = (acks == 0) ? 16'h1111 : 16'h2222;
        acks++;
      end
      if (bus.rsp_valid) begin
        if (cnt < 2) begin
          rsp_n[cnt] = n;
          rd_b[cnt]  = bus.rsp_rdata;
        end
        cnt++;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    check_vec("b2b_accepts", accepts, 2);
    check_vec("b2b_acc0", acc_at[0], 0);
    check_vec("b2b_acc1", acc_at[1], 6);
    check_vec("b2b_rsp0", rsp_n[0], 5);
    check_vec("b2b_rsp1", rsp_n[1], 11);
    check_vec("b2b_rdata0", rd_b[0], 16'h1111);
    check_vec("b2b_rdata1", rd_b[1], 16'h2222);
    check_vec("b2b_pulses", cnt, 2);
    check_vec("ref_rd_const", ref_rd_low, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/obj_mem_ctrl.md
# obj_mem_ctrl

Object memory access sequencer that sits directly downstream of the object reference table. It accepts object-relative load/store requests as an object number plus byte offset, and drives the table lookup to get the absolute 16-bit location. It then performs one data-memory transaction over a req/ack handshake and returns a single-cycle response with read data and error status.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles `mem_req` stays high waiting for `mem_ack` before the access is abandoned; legal range 1–255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle and able to accept.
- `req_we`  in  1  1 = store, 0 = load.
- `req_obj`  in  4  object number.
- `req_off`  in  8  byte offset within object.
- `req_wdata`  in  16  store data.
- `ref_ptr`  out  4  object number to table.
- `ref_off`  out  8  offset to table.
- `ref_rd`  out  1  table read strobe; constant 1, including during reset. Table writes are never issued by this block.
- `ref_loc`  in  16  table result (base + offset), registered in the table.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  16  memory write data.
- `mem_ack`  in  1  memory completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  16  memory read data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  16  load data; 0 for stores and for errors.
- `rsp_err`  out  1  access failed; valid while `rsp_valid` is high.

## Operation
- FSM states: `IDLE` → `LOOKUP` → `CAPTURE` → `MEM` → `DONE` → `IDLE`.
- `IDLE`
  - `req_ready` = 1.
  - On `req_valid` the block registers `req_we`, `req_obj`, `req_off` and `req_wdata`, then moves to `LOOKUP`.
- `LOOKUP`
  - `ref_ptr`/`ref_off` are driven from the registered request.
  - The table samples them on the closing edge.
- `CAPTURE`
  - `ref_loc` is now valid and is registered into `mem_addr`.
  - Next state is `MEM`, or `DONE` with the error flag set if the address check fails (see Configuration).
- `MEM`
  - `mem_req` = 1, with `mem_we`/`mem_wdata` from the registered request.
  - On `mem_ack`: latch `mem_rdata` (loads only; stores latch 0), drop `mem_req` and go to `DONE`.
  - A timeout counter counts `MEM` cycles. If `TIMEOUT` cycles elapse without `mem_ack`, set the error flag, drop `mem_req` and go to `DONE`.
- `DONE`
  - `rsp_valid` = 1 for exactly one cycle.
  - `rsp_rdata` and `rsp_err` are held stable until the next `DONE`.
  - There is no response backpressure.
- Only one outstanding request at a time. `req_valid` outside `IDLE` is ignored; the requester holds it.
- `mem_ack` outside `MEM` is ignored.
- No address arithmetic is done here; `ref_loc` is used unmodified.

## Timing
- Reset values:
  - state `IDLE`
  - `req_ready` 1, `ref_rd` 1
  - `ref_ptr` 0, `ref_off` 0
  - `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0
  - `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0
- Accept edge = E.
  - `mem_req` rises after E+3.
  - With `mem_ack` in the first `MEM` cycle, `rsp_valid` is high in the cycle after E+4, so latency is 4.
  - Each extra wait cycle adds 1.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then `rsp_valid` with `rsp_err` = 1 and `rsp_rdata` = 0.
- Address-check error: `rsp_valid` after E+3, and `mem_req` is never asserted.
- `mem_ack` arriving in the same cycle the timeout expires counts as success.
- `rst` asserted mid-operation forces all outputs to reset values immediately, including an in-flight `mem_req` and a pending response. No response is issued for the aborted request.

## Configuration
- `OBJ_ADDR_CHECK_EN` defined:
  - In `CAPTURE`, an error is flagged and `MEM` is skipped when `req_obj` ≥ 8, or when `ref_loc` < 16'h0100 or > 16'h08FF.
  - These cases cover unpopulated table entries and address wrap.
- Not defined:
  - No check is made; every request proceeds to `MEM`.
  - `rsp_err` comes only from the timeout.

## Test plan
- Table default, object 2 = 16'h0300: load obj 2, off 8'h10; `mem_ack` in first `MEM` cycle with `mem_rdata` 16'hBEEF → `mem_addr` 16'h0310, `mem_we` 0; `rsp_valid` after E+4 with `rsp_rdata` 16'hBEEF, `rsp_err` 0.
- Store obj 7, off 8'hFF, `req_wdata` 16'h1234; `mem_ack` delayed 3 cycles → `mem_addr` 16'h08FF, `mem_we` 1, `mem_wdata` 16'h1234; `mem_req` high 4 cycles; `rsp_valid` after E+7 with `rsp_rdata` 0, `rsp_err` 0.
- Load obj 1, `mem_ack` never asserted, `TIMEOUT` 15 → `mem_req` high exactly 15 cycles; then `rsp_err` 1, `rsp_rdata` 0; `req_ready` returns to 1 the following cycle.
- With `OBJ_ADDR_CHECK_EN`: load obj 9 → no `mem_req`; `rsp_valid` after E+3 with `rsp_err` 1. Without the macro, the same request reaches `MEM` with whatever `ref_loc` the table returns.
- Assert `rst` during `MEM` (`mem_req` = 1) → `mem_req` 0 immediately, no `rsp_valid`. A new load on obj 0, off 0 after release gives `mem_addr` 16'h0100 and completes normally.
- Back-to-back: hold `req_valid` high across two loads → second accept only in the `IDLE` cycle after the first `DONE`; `ref_rd` stays 1 throughout.
